// File: rtl/vend_pkg.sv
// Shared types and constants for the change dispense controller.
// Optional timeout/fault feature: CHANGE_DISP_TIMEOUT_EN.
package vend_pkg;

    // Width of the change count; one LSB is one nickel.
    localparam int CHG_W = 3;

    // Value of one change unit in cents.
    localparam int NICKEL_CENTS = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SODA_ON   = 3'd1,
        ST_SODA_WAIT = 3'd2,
        ST_COIN_ON   = 3'd3,
        ST_COIN_WAIT = 3'd4,
        ST_DONE      = 3'd5,
        ST_FAULT     = 3'd6
    } disp_state_t;

    // Converts a nickel count into cents.
    function automatic int change_cents(input logic [CHG_W-1:0] nickels);
        return int'(nickels) * NICKEL_CENTS;
    endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Vend request bus between the vend-decision FSM and the dispense controller.
// Signal names carry the direction as seen from the controller.
//
// Handshake: a request transfers on a rising clock edge where req_valid_i and
// req_ready_o are both high. The requester holds req_soda_i/req_change_i
// stable while req_valid_i is high and not yet accepted; the controller
// ignores the request fields whenever req_ready_o is low.
interface change_dispense_ctrl_if;
    import vend_pkg::*;

    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_soda_i;
    logic [CHG_W-1:0] req_change_i;

    modport master (
        output req_valid_i,
        output req_soda_i,
        output req_change_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i,
        input  req_soda_i,
        input  req_change_i,
        output req_ready_o
    );

endinterface

// File: rtl/cyc_timer.sv
// Down-counter shared by the actuator pulse and the sense-wait timeout.
// load_i presets the count; the count then steps down while count_en_i is
// high and stops at zero. expired_o is high while the count is zero, so a
// load value of N-1 gives exactly N cycles up to and including expiry.
module cyc_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         count_en_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority over counting; counting saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/change_dispense_ctrl.sv
// Vend mechanism sequencer: one soda pulse (optional) followed by one nickel
// ejection per owed nickel, each action confirmed by its sense input.
// Optional feature macro: CHANGE_DISP_TIMEOUT_EN (sense-wait timeout -> FAULT).
module change_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int PULSE_CYC   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    change_dispense_ctrl_if.slave  req,
    output logic                   soda_motor_o,
    input  logic                   soda_sense_i,
    output logic                   coin_eject_o,
    input  logic                   coin_sense_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CHG_W-1:0]       pending_o,
    output logic                   fault_o,
    input  logic                   fault_clr_i,
    output disp_state_t            dbg_state_o
);

    // One timer serves both the pulse length and the wait timeout.
    localparam int TMR_MAX = (PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] PULSE_LOAD   = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYC - 1);

    disp_state_t       state_q, state_d;
    logic [CHG_W-1:0]  pending_q, pending_d;
    logic              ready_q;
    logic              motor_q;
    logic              eject_q;
    logic              busy_q;
    logic              done_q;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_load_val;
    logic              tmr_count_en;
    logic              tmr_expired;

    cyc_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .count_en_i (tmr_count_en),
        .expired_o  (tmr_expired)
    );

    // Next-state, pending count and timer control.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_count_en = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (req.req_valid_i && ready_q) begin
                    pending_d = req.req_change_i;
                    if (req.req_soda_i) begin
                        state_d = ST_SODA_ON;
                    end else if (req.req_change_i != '0) begin
                        state_d = ST_COIN_ON;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SODA_ON: begin
                if (tmr_expired) begin
                    state_d = ST_SODA_WAIT;
                end
            end
            ST_SODA_WAIT: begin
                // Sense is checked first so a sense on the expiry cycle wins.
                if (soda_sense_i) begin
                    state_d = (pending_q != '0) ? ST_COIN_ON : ST_DONE;
                end
`ifdef CHANGE_DISP_TIMEOUT_EN
                else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
`endif
            end
            ST_COIN_ON: begin
                if (tmr_expired) begin
                    state_d = ST_COIN_WAIT;
                end
            end
            ST_COIN_WAIT: begin
                if (coin_sense_i) begin
                    if (pending_q != '0) begin
                        pending_d = pending_q - 1'b1;
                    end
                    state_d = (pending_d != '0) ? ST_COIN_ON : ST_DONE;
                end
`ifdef CHANGE_DISP_TIMEOUT_EN
                else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
`ifdef CHANGE_DISP_TIMEOUT_EN
                // Owed change stays visible until the fault is acknowledged.
                if (fault_clr_i) begin
                    state_d   = ST_IDLE;
                    pending_d = '0;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every entry into an ON or WAIT state restarts the timer.
        if (state_d != state_q) begin
            case (state_d)
                ST_SODA_ON, ST_COIN_ON: begin
                    tmr_load     = 1'b1;
                    tmr_load_val = PULSE_LOAD;
                end
                ST_SODA_WAIT, ST_COIN_WAIT: begin
                    tmr_load     = 1'b1;
                    tmr_load_val = TIMEOUT_LOAD;
                end
                default: begin
                    tmr_load     = 1'b0;
                    tmr_load_val = '0;
                end
            endcase
        end
    end

    // State and registered outputs, all derived from the next state so they
    // change on the same edge that moves the FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            ready_q   <= 1'b1;
            motor_q   <= 1'b0;
            eject_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ready_q   <= (state_d == ST_IDLE);
            motor_q   <= (state_d == ST_SODA_ON);
            eject_q   <= (state_d == ST_COIN_ON);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
        end
    end

`ifdef CHANGE_DISP_TIMEOUT_EN
    logic fault_q;

    // Fault flag: set while the FSM sits in FAULT, cleared by acknowledgement.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign fault_o = fault_q;
`else
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr_i;
    assign fault_o          = 1'b0;
`endif

    assign req.req_ready_o = ready_q;
    assign soda_motor_o    = motor_q;
    assign coin_eject_o    = eject_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pending_o       = pending_q;
    assign dbg_state_o     = state_q;

endmodule
